// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    localparam int          MDU_ITER = 32;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/mdu_seq_if.sv
// EX-side request/response bundle between the pipeline and the M-extension sequencer.
interface mdu_seq_if;

    logic        flush;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;

    modport master (
        output flush, start_valid, func3, op_a, op_b, result_ready,
        input  start_ready, busy, result_valid, result
    );

    modport slave (
        input  flush, start_valid, func3, op_a, op_b, result_ready,
        output start_ready, busy, result_valid, result
    );

endinterface

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, trial-subtract divisor.
module mdu_divstep (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_nx,
    output logic [31:0] quo_nx
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // The shifted remainder needs 33 bits; after a successful subtract it fits 32 again.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, divisor};
    assign rem_nx  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nx  = {quo[30:0], ~diff[32]};

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// one op in flight, result returned under a valid/ready handshake.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter bit FAST_PATH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_seq_if.slave   mdu
);

    mdu_state_t  state_q;
    logic [4:0]  cnt_q;
    md_op_t      op_q;
    logic [63:0] acc_q;
    logic [31:0] dvsr_q;
    logic        neg_q;
    logic        spec_q;
    logic [31:0] spec_val_q;
    logic [31:0] res_q;
    logic        res_vld_q;

    md_op_t      op_in;
    logic        a_signed;
    logic        b_signed;
    logic        sa;
    logic        sb;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        is_div;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] spec_val;
    logic        neg_in;

    assign op_in = md_op_t'(mdu.func3);
    assign is_div = mdu.func3[2];

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        sa    = a_signed & mdu.op_a[31];
        sb    = b_signed & mdu.op_b[31];
        mag_a = sa ? (~mdu.op_a + 32'd1) : mdu.op_a;
        mag_b = sb ? (~mdu.op_b + 32'd1) : mdu.op_b;
        // The remainder follows the dividend's sign; products and quotients follow sa^sb.
        neg_in = (op_in == OP_REM) ? sa : (sa ^ sb);
    end

    always_comb begin
        div_zero = is_div & (mdu.op_b == 32'd0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &
                   (mdu.op_a == INT_MIN) & (mdu.op_b == 32'hFFFF_FFFF);
        special  = div_zero | div_ovf;
        spec_val = 32'd0;
        if (div_zero)
            spec_val = mdu.func3[1] ? mdu.op_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            spec_val = mdu.func3[1] ? 32'd0 : INT_MIN;
    end

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [63:0] iter_next;

    // Multiplier sits in the low half and is consumed LSB-first as the sum shifts in from the top.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? dvsr_q : 32'd0)};
    assign mul_next = {mul_sum, acc_q[31:1]};

    mdu_divstep u_divstep (
        .rem     (acc_q[63:32]),
        .quo     (acc_q[31:0]),
        .divisor (dvsr_q),
        .rem_nx  (div_rem),
        .quo_nx  (div_quo)
    );

    assign iter_next = (state_q == MUL) ? mul_next : {div_rem, div_quo};

    logic [63:0] mul_fin;
    logic [31:0] div_sel;
    logic [31:0] div_fin;
    logic [31:0] res_next;

    always_comb begin
        mul_fin = neg_q ? (~mul_next + 64'd1) : mul_next;
        div_sel = op_q[1] ? div_rem : div_quo;
        div_fin = neg_q ? (~div_sel + 32'd1) : div_sel;
        unique case (op_q)
            OP_MUL:                       res_next = mul_fin[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_next = mul_fin[63:32];
            default:                      res_next = div_fin;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            op_q       <= OP_MUL;
            acc_q      <= 64'd0;
            dvsr_q     <= 32'd0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            res_q      <= 32'd0;
            res_vld_q  <= 1'b0;
        end else if (mdu.flush) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            res_vld_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mdu.start_valid) begin
                        op_q       <= op_in;
                        neg_q      <= neg_in;
                        spec_q     <= special;
                        spec_val_q <= spec_val;
                        cnt_q      <= 5'd0;
                        if (is_div) begin
                            acc_q  <= {32'd0, mag_a};
                            dvsr_q <= mag_b;
                        end else begin
                            acc_q  <= {32'd0, mag_b};
                            dvsr_q <= mag_a;
                        end
                        if (FAST_PATH && special) begin
                            state_q   <= DONE;
                            res_q     <= spec_val;
                            res_vld_q <= 1'b1;
                        end else begin
                            state_q <= is_div ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= iter_next;
                    cnt_q <= cnt_q + 5'd1;
                    // The last iteration and result formatting share this edge.
                    if (cnt_q == 5'(MDU_ITER - 1)) begin
                        state_q   <= DONE;
                        res_q     <= spec_q ? spec_val_q : res_next;
                        res_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (mdu.result_ready) begin
                        state_q   <= IDLE;
                        res_vld_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mdu.start_ready  = rst_n & ~mdu.flush & (state_q == IDLE);
    assign mdu.busy         = (state_q != IDLE);
    assign mdu.result_valid = res_vld_q;
    assign mdu.result       = res_q;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in EX.
- Accepts one operation per handshake, holds the pipeline through `busy` while it runs, and returns a 32-bit result under a valid/ready handshake.
- Uses the same `func3` selection style as the ALU. A radix-2 shift-add multiply and restoring divide are sequenced by an FSM and a 5-bit iteration counter.

Parameters:
- FAST_PATH, 1: when 1, divide-by-zero and signed overflow (-2^31 / -1) complete without iterating. When 0, every op takes the full iteration latency.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; drops any in-flight op or pending result
- start_valid  in  1  EX presents an M-extension op
- start_ready  out  1  sequencer can accept an op
- func3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  in  32  rs1 value
- op_b  in  32  rs2 value
- busy  out  1  op accepted and result not yet consumed (pipeline stall)
- result_valid  out  1  result holds a completed value
- result_ready  in  1  writeback consumes the result
- result  out  32  completed value

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, all internal registers 0.
  - start_ready=0 while in reset; it follows the IDLE rule below once out of reset.
  - busy=0, result_valid=0, result=0.
- States:
  - IDLE -> MUL or DIV on accept. With FAST_PATH=1, a special divide goes IDLE -> DONE.
  - MUL or DIV -> DONE when the counter reaches 31.
  - DONE -> IDLE when result_valid & result_ready.
- Handshakes:
  - start_ready = (state==IDLE) & ~flush.
  - Accept = start_valid & start_ready. func3, op_a and op_b are captured only on accept; later input changes are ignored.
  - busy = (state!=IDLE).
- Latency:
  - Accept at edge N; iterations run in cycles N+1 .. N+32; result_valid=1 from cycle N+33.
  - FAST_PATH special cases: result_valid=1 from cycle N+1.
- Operand preparation on accept:
  - Signed operands are converted to magnitude; the result sign is recorded.
  - MULH: both operands signed. MULHSU: only op_a signed. DIV/REM: both signed.
  - Result sign: product = sa^sb; quotient = sa^sb; remainder = sa (sign of dividend).
- MUL iteration:
  - 64-bit accumulator.
  - Each cycle: if multiplier LSB is 1, add the multiplicand into the upper half; then shift right 1.
- DIV iteration:
  - Shift {rem,quo} left 1.
  - Trial-subtract the divisor from rem. If non-negative, keep the difference and set quo LSB=1.
- DONE entry:
  - Apply two's-complement negate (64-bit for products) if the recorded sign is set.
  - Select output: low word for MUL; high word for MULH, MULHSU, MULHU; quo for DIV/DIVU; rem for REM/REMU.
  - Register into `result`.
- Special cases (results identical with FAST_PATH=0 or 1):
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - Overflow, DIV with 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- result and result_valid hold stable while result_ready=0; back-pressure has no length limit.
- Flush:
  - Any state -> IDLE at the next edge; result_valid=0 and the counter is cleared.
  - Flush in the same cycle as start_valid: no accept.
  - Flush in the same cycle as result_ready in DONE: result is dropped, state goes to IDLE.
- Reset mid-operation: immediate return to reset values; no partial result is ever presented.
- The counter is 5 bits, loads 0 on accept, and its wrap from 31 is never used as a condition.

Decomposition:
- Shared defs package gains:
  - `md_op_t` enum (the 8 func3 codes above).
  - `mdu_state_t` enum {IDLE, MUL, DIV, DONE}.
  - Localparams MDU_ITER=32 and INT_MIN=32'h8000_0000.
- One combinational sub-module, `mdu_divstep`: one restoring-division step. Inputs: rem, quo, divisor. Outputs: next rem, next quo.
- Negation and output selection stay inline.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), result_ready=1 -> result=0xFFFFFFEB with result_valid exactly 33 cycles after accept; start_ready=0 and busy=1 throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV by 0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both at cycle N+1 with FAST_PATH=1 and N+33 with FAST_PATH=0; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Hold result_ready=0 for 10 cycles in DONE -> result and result_valid stable, start_ready=0. Then one-cycle result_ready -> IDLE next cycle; back-to-back accept succeeds.
- Flush at iteration 10 of DIVU -> IDLE next edge, no result_valid pulse. Separately, rst_n low at iteration 20 of MUL -> all outputs 0 immediately; the next op completes correctly.
